// File: rtl/mnist_pkg.sv
// Shared constants, FSM state type and elaboration helpers for the MNIST
// datapath blocks.
package mnist_pkg;

  localparam int unsigned FEATURE_BITWIDTH = 8;
  localparam int unsigned FLATTENED_SIZE   = 288;
  localparam int unsigned FC_LANES         = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } sched_state_e;

  // Bits needed to index 'value' entries; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/fc_feed_scheduler_if.sv
// Frame-in / beat-out bus of the FC feed scheduler. 'slave' is the
// scheduler side, 'master' the environment (flatten producer + FC consumer).
interface fc_feed_scheduler_if #(
  parameter int unsigned FEATURE_BITWIDTH = mnist_pkg::FEATURE_BITWIDTH,
  parameter int unsigned FLATTENED_SIZE   = mnist_pkg::FLATTENED_SIZE,
  parameter int unsigned LANES            = mnist_pkg::FC_LANES
);
  import mnist_pkg::*;

  localparam int unsigned NUM_BEATS = ceil_div(FLATTENED_SIZE, LANES);
  localparam int unsigned IDX_W     = clog2(NUM_BEATS);

  logic                                   vec_valid;
  logic                                   vec_ready;
  logic [FEATURE_BITWIDTH*FLATTENED_SIZE-1:0] vec_in;
  logic                                   beat_valid;
  logic                                   beat_ready;
  logic [FEATURE_BITWIDTH*LANES-1:0]      beat_data;
  logic [IDX_W-1:0]                       beat_idx;
  logic                                   beat_last;
  logic                                   frame_done;
  logic                                   busy;
  logic [15:0]                            frame_count;

  modport slave (
    input  vec_valid, vec_in, beat_ready,
    output vec_ready, beat_valid, beat_data, beat_idx, beat_last,
           frame_done, busy, frame_count
  );

  modport master (
    output vec_valid, vec_in, beat_ready,
    input  vec_ready, beat_valid, beat_data, beat_idx, beat_last,
           frame_done, busy, frame_count
  );

endinterface

// File: rtl/flat_beat_select.sv
// Combinational beat slicer: picks LANES elements of the frame buffer for a
// given beat index; lanes past the end of the frame read as zero.
module flat_beat_select #(
  parameter int unsigned FEATURE_BITWIDTH = mnist_pkg::FEATURE_BITWIDTH,
  parameter int unsigned FLATTENED_SIZE   = mnist_pkg::FLATTENED_SIZE,
  parameter int unsigned LANES            = mnist_pkg::FC_LANES
) (
  input  logic [FEATURE_BITWIDTH*FLATTENED_SIZE-1:0]               i_buf,
  input  logic [mnist_pkg::clog2(mnist_pkg::ceil_div(FLATTENED_SIZE, LANES))-1:0] i_idx,
  output logic [FEATURE_BITWIDTH*LANES-1:0]                        o_data
);
  import mnist_pkg::*;

  localparam int unsigned NUM_BEATS = ceil_div(FLATTENED_SIZE, LANES);
  localparam int unsigned IDX_W     = clog2(NUM_BEATS);
  localparam int unsigned BEAT_BITS = FEATURE_BITWIDTH * LANES;
  localparam int unsigned PAD_BITS  = NUM_BEATS * BEAT_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  // Buffer zero-extended to a whole number of beats, so the partial last
  // beat gets its zero padding for free from the width cast.
  logic [NUM_BEATS-1:0][BEAT_BITS-1:0] w_padded;

  // Select the addressed beat; out-of-range indices yield zero.
  always_comb begin
    w_padded = PAD_BITS'(i_buf);
    o_data   = '0;
    if (i_idx <= LAST_IDX) begin
      o_data = w_padded[i_idx];
    end
  end

endmodule

// File: rtl/fc_feed_scheduler.sv
// Captures one flattened feature vector and streams it to the FC stage as
// LANES-wide beats with index, last flag and back-pressure.
module fc_feed_scheduler #(
  parameter int unsigned FEATURE_BITWIDTH = mnist_pkg::FEATURE_BITWIDTH,
  parameter int unsigned FLATTENED_SIZE   = mnist_pkg::FLATTENED_SIZE,
  parameter int unsigned LANES            = mnist_pkg::FC_LANES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               soft_rst,
  fc_feed_scheduler_if.slave bus
);
  import mnist_pkg::*;

  localparam int unsigned NUM_BEATS = ceil_div(FLATTENED_SIZE, LANES);
  localparam int unsigned IDX_W     = clog2(NUM_BEATS);
  localparam int unsigned BUF_BITS  = FEATURE_BITWIDTH * FLATTENED_SIZE;
  localparam int unsigned BEAT_BITS = FEATURE_BITWIDTH * LANES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  sched_state_e         r_state;
  sched_state_e         w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 r_frame_done;
  logic                 w_done_nxt;
  logic [15:0]          r_frame_count;
  logic [BUF_BITS-1:0]  r_buf;
  logic                 w_capture;
  logic                 w_vec_ready;
  logic                 w_beat_valid;
  logic [BEAT_BITS-1:0] w_slice;

  // State, beat index, done pulse and frame counter; soft_rst mirrors rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else if (soft_rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_frame_done <= w_done_nxt;
      if (w_done_nxt) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  // Frame buffer; contents are don't-care outside a frame, so no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf <= bus.vec_in;
    end
  end

  // Next-state and handshake decode; vec_ready depends on state only.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_done_nxt   = 1'b0;
    w_capture    = 1'b0;
    w_vec_ready  = 1'b0;
    w_beat_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_vec_ready = 1'b1;
        if (bus.vec_valid) begin
          // A same-cycle soft_rst wins, so the buffer write is suppressed too.
          w_capture   = !soft_rst;
          w_idx_nxt   = '0;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        w_beat_valid = 1'b1;
        if (bus.beat_ready) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  flat_beat_select #(
    .FEATURE_BITWIDTH (FEATURE_BITWIDTH),
    .FLATTENED_SIZE   (FLATTENED_SIZE),
    .LANES            (LANES)
  ) u_beat_select (
    .i_buf  (r_buf),
    .i_idx  (r_idx),
    .o_data (w_slice)
  );

  assign bus.vec_ready   = w_vec_ready;
  assign bus.beat_valid  = w_beat_valid;
  assign bus.busy        = w_beat_valid;
  assign bus.beat_idx    = r_idx;
  assign bus.beat_last   = w_beat_valid && (r_idx == LAST_IDX);
  assign bus.beat_data   = w_beat_valid ? w_slice : '0;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_fc_feed_scheduler.sv
// Directed bench for fc_feed_scheduler: a 288-element instance and a
// 20-element instance, each compared every cycle against a frame-level model.
module tb_fc_feed_scheduler;

  localparam int unsigned W       = 8;
  localparam int unsigned L       = 8;
  localparam int unsigned NA      = 288;
  localparam int unsigned NB      = 20;
  localparam int unsigned BEATS_A = 36;
  localparam int unsigned BEATS_B = 3;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic soft_rst = 1'b0;
  always #5 clk = ~clk;

  fc_feed_scheduler_if #(.FEATURE_BITWIDTH(W), .FLATTENED_SIZE(NA), .LANES(L)) ifa ();
  fc_feed_scheduler_if #(.FEATURE_BITWIDTH(W), .FLATTENED_SIZE(NB), .LANES(L)) ifb ();

  fc_feed_scheduler #(.FEATURE_BITWIDTH(W), .FLATTENED_SIZE(NA), .LANES(L)) dut_a (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .bus(ifa)
  );
  fc_feed_scheduler #(.FEATURE_BITWIDTH(W), .FLATTENED_SIZE(NB), .LANES(L)) dut_b (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .bus(ifb)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int kind, input int e);
    case (kind)
      0:       return 8'(e);
      1:       return 8'(e * 3 + 5);
      2:       return 8'(255 - e);
      default: return 8'(160 + e);
    endcase
  endfunction

  // Expected beat: element beat*L+lane in each lane, zero beyond 'size'.
  function automatic logic [63:0] exp_beat(input int beat, input int size, input logic [7:0] el [NA]);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < int'(L); l++) begin
      if (beat * int'(L) + l < size) r[l*8 +: 8] = el[beat * int'(L) + l];
    end
    return r;
  endfunction

  // Frame-level model: a captured frame, the beat the consumer is owed next,
  // a done flag for the cycle after the final accept, and a frame counter.
  logic [7:0]  ma_elem [NA];
  bit          ma_active = 1'b0;
  int          ma_beat   = 0;
  bit          ma_done   = 1'b0;
  logic [15:0] ma_count  = '0;
  logic [7:0]  mb_elem [NA];
  bit          mb_active = 1'b0;
  int          mb_beat   = 0;
  bit          mb_done   = 1'b0;
  logic [15:0] mb_count  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || soft_rst) begin
      ma_active = 1'b0; ma_beat = 0; ma_done = 1'b0; ma_count = '0;
      mb_active = 1'b0; mb_beat = 0; mb_done = 1'b0; mb_count = '0;
    end else begin
      ma_done = 1'b0;
      if (!ma_active) begin
        if (ifa.vec_valid) begin
          for (int e = 0; e < int'(NA); e++) ma_elem[e] = ifa.vec_in[e*W +: W];
          ma_active = 1'b1;
          ma_beat   = 0;
        end
      end else if (ifa.beat_ready) begin
        if (ma_beat == int'(BEATS_A) - 1) begin
          ma_active = 1'b0; ma_done = 1'b1; ma_count = ma_count + 16'd1;
        end else begin
          ma_beat++;
        end
      end
      mb_done = 1'b0;
      if (!mb_active) begin
        if (ifb.vec_valid) begin
          for (int e = 0; e < int'(NB); e++) mb_elem[e] = ifb.vec_in[e*W +: W];
          mb_active = 1'b1;
          mb_beat   = 0;
        end
      end else if (ifb.beat_ready) begin
        if (mb_beat == int'(BEATS_B) - 1) begin
          mb_active = 1'b0; mb_done = 1'b1; mb_count = mb_count + 16'd1;
        end else begin
          mb_beat++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("a_vec_ready",   ifa.vec_ready,   !ma_active);
      check("a_beat_valid",  ifa.beat_valid,  ma_active);
      check("a_busy",        ifa.busy,        ma_active);
      check("a_frame_done",  ifa.frame_done,  ma_done);
      check("a_frame_count", ifa.frame_count, ma_count);
      check("a_beat_last",   ifa.beat_last,   ma_active && ma_beat == int'(BEATS_A) - 1);
      if (ma_active) begin
        check("a_beat_idx",  ifa.beat_idx,  ma_beat);
        check("a_beat_data", ifa.beat_data, exp_beat(ma_beat, NA, ma_elem));
      end else begin
        check("a_beat_data_idle", ifa.beat_data, 64'd0);
      end
      check("b_vec_ready",   ifb.vec_ready,   !mb_active);
      check("b_beat_valid",  ifb.beat_valid,  mb_active);
      check("b_frame_done",  ifb.frame_done,  mb_done);
      check("b_frame_count", ifb.frame_count, mb_count);
      check("b_beat_last",   ifb.beat_last,   mb_active && mb_beat == int'(BEATS_B) - 1);
      if (mb_active) begin
        check("b_beat_idx",  ifb.beat_idx,  mb_beat);
        check("b_beat_data", ifb.beat_data, exp_beat(mb_beat, NB, mb_elem));
      end else begin
        check("b_beat_data_idle", ifb.beat_data, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input int kind);
    for (int e = 0; e < int'(NA); e++) ifa.vec_in[e*W +: W] = pat(kind, e);
  endtask

  task automatic wait_done_a(input int budget, input string tag);
    int n;
    n = 0;
    while (ifa.frame_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, ifa.frame_done, 1'b1);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int          acc[$];
    bit          seen_done;
    bit          stalled_prev;
    logic [5:0]  prev_idx;
    logic [63:0] prev_data;
    int          last_acc_cyc;

    ifa.vec_valid = 1'b0; ifa.vec_in = '0; ifa.beat_ready = 1'b1;
    ifb.vec_valid = 1'b0; ifb.vec_in = '0; ifb.beat_ready = 1'b1;
    repeat (2) tick();

    // Reset values
    check("rst_vec_ready",   ifa.vec_ready,   1'b1);
    check("rst_beat_valid",  ifa.beat_valid,  1'b0);
    check("rst_busy",        ifa.busy,        1'b0);
    check("rst_beat_idx",    ifa.beat_idx,    6'd0);
    check("rst_beat_last",   ifa.beat_last,   1'b0);
    check("rst_frame_done",  ifa.frame_done,  1'b0);
    check("rst_frame_count", ifa.frame_count, 16'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Test 1: ramp pattern, beat_ready tied high, 37-cycle frame
    load_a(0);
    ifa.vec_valid = 1'b1;
    tick();
    ifa.vec_valid = 1'b0;
    check("t1_b0_valid", ifa.beat_valid, 1'b1);
    check("t1_b0_idx",   ifa.beat_idx,   6'd0);
    check("t1_b0_data",  ifa.beat_data,  64'h0706050403020100);
    repeat (35) tick();
    check("t1_b35_idx",  ifa.beat_idx,   6'd35);
    check("t1_b35_data", ifa.beat_data,  64'h1F1E1D1C1B1A1918);
    check("t1_b35_last", ifa.beat_last,  1'b1);
    tick();
    check("t1_done",      ifa.frame_done,  1'b1);
    check("t1_count",     ifa.frame_count, 16'd1);
    check("t1_vec_ready", ifa.vec_ready,   1'b1);
    check("t1_valid_low", ifa.beat_valid,  1'b0);
    tick();
    check("t1_done_pulse", ifa.frame_done, 1'b0);

    // Test 2: beat_ready low on odd cycles
    load_a(1);
    ifa.vec_valid = 1'b1;
    tick();
    ifa.vec_valid = 1'b0;
    check("t2_b0_data", ifa.beat_data, 64'h1A1714110E0B0805);
    seen_done    = 1'b0;
    stalled_prev = 1'b0;
    prev_idx     = '0;
    prev_data    = '0;
    last_acc_cyc = -10;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      ifa.beat_ready = (cyc % 2 == 0);
      #3;
      if (stalled_prev) begin
        check("t2_stall_idx",  ifa.beat_idx,  prev_idx);
        check("t2_stall_data", ifa.beat_data, prev_data);
      end
      if (ifa.frame_done) begin
        seen_done = 1'b1;
        check("t2_accepts_before_done", acc.size(), 36);
        check("t2_done_after_last",     cyc,        last_acc_cyc + 1);
      end else begin
        if (ifa.beat_valid && ifa.beat_ready) begin
          acc.push_back(int'(ifa.beat_idx));
          last_acc_cyc = cyc;
        end
        stalled_prev = ifa.beat_valid && !ifa.beat_ready;
        prev_idx     = ifa.beat_idx;
        prev_data    = ifa.beat_data;
        tick();
      end
    end
    check("t2_done_seen", seen_done, 1'b1);
    for (int i = 0; i < acc.size(); i++) check("t2_beat_order", acc[i], i);
    ifa.beat_ready = 1'b1;
    tick();

    // Test 3: vec_valid held with a new vector during streaming
    load_a(2);
    ifa.vec_valid = 1'b1;
    tick();
    load_a(3);
    for (int i = 0; i < 36; i++) begin
      check("t3_vec_ready_low", ifa.vec_ready, 1'b0);
      tick();
    end
    check("t3_done",      ifa.frame_done, 1'b1);
    check("t3_vec_ready", ifa.vec_ready,  1'b1);
    tick();
    ifa.vec_valid = 1'b0;
    check("t3_second_valid", ifa.beat_valid, 1'b1);
    check("t3_second_b0",    ifa.beat_data,  64'hA7A6A5A4A3A2A1A0);
    wait_done_a(50, "t3_second_done");
    check("t3_count", ifa.frame_count, 16'd4);
    tick();

    // Test 5: asynchronous reset in the middle of a beat
    load_a(2);
    ifa.vec_valid = 1'b1;
    tick();
    ifa.vec_valid = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_beat_valid", ifa.beat_valid,  1'b0);
    check("t5_vec_ready",  ifa.vec_ready,   1'b1);
    check("t5_busy",       ifa.busy,        1'b0);
    check("t5_beat_idx",   ifa.beat_idx,    6'd0);
    check("t5_beat_data",  ifa.beat_data,   64'd0);
    check("t5_count",      ifa.frame_count, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Test 4: soft reset at beat 10, then soft_rst together with vec_valid
    load_a(0);
    ifa.vec_valid = 1'b1;
    tick();
    ifa.vec_valid = 1'b0;
    repeat (10) tick();
    check("t4_at_beat10", ifa.beat_idx, 6'd10);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("t4_beat_valid", ifa.beat_valid,  1'b0);
    check("t4_vec_ready",  ifa.vec_ready,   1'b1);
    check("t4_beat_idx",   ifa.beat_idx,    6'd0);
    check("t4_count",      ifa.frame_count, 16'd0);
    soft_rst      = 1'b1;
    ifa.vec_valid = 1'b1;
    tick();
    soft_rst      = 1'b0;
    ifa.vec_valid = 1'b0;
    check("t4_no_capture", ifa.beat_valid, 1'b0);
    for (int i = 0; i < 40; i++) begin
      check("t4_no_done", ifa.frame_done, 1'b0);
      tick();
    end

    // Test 6: 20-element instance, partial last beat
    for (int e = 0; e < int'(NB); e++) ifb.vec_in[e*W +: W] = pat(0, e);
    ifb.vec_valid = 1'b1;
    tick();
    ifb.vec_valid = 1'b0;
    check("t6_b0_data", ifb.beat_data, 64'h0706050403020100);
    check("t6_b0_last", ifb.beat_last, 1'b0);
    tick();
    check("t6_b1_data", ifb.beat_data, 64'h0F0E0D0C0B0A0908);
    tick();
    check("t6_b2_idx",  ifb.beat_idx,  2'd2);
    check("t6_b2_data", ifb.beat_data, 64'h0000000013121110);
    check("t6_b2_last", ifb.beat_last, 1'b1);
    tick();
    check("t6_done",  ifb.frame_done,  1'b1);
    check("t6_count", ifb.frame_count, 16'd1);
    tick();
    check("t6_done_pulse", ifb.frame_done, 1'b0);
    tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_feed_scheduler.md
Name: fc_feed_scheduler

Overview:
Sequences the flattened feature vector into the fully connected stage. It accepts one complete flattened vector (6x6x8 = 288 elements) through a valid/ready handshake and stores it in an internal frame buffer. It then streams the vector as fixed-width beats of LANES elements, with beat index, last flag and back-pressure. It sits between the flatten layer output and the FC layer's MAC array, so the FC datapath can consume a narrow slice per cycle.

Parameters:
FEATURE_BITWIDTH, 8, bits per element
FLATTENED_SIZE, 288, elements per frame
LANES, 8, elements per output beat
NUM_BEATS, ceil(FLATTENED_SIZE/LANES) = 36, derived localparam, not overridable
IDX_W, clog2(NUM_BEATS) = 6, derived localparam, beat index width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
soft_rst  in  1  synchronous clear, same effect as reset
vec_valid  in  1  flattened vector present on vec_in
vec_ready  out  1  scheduler can capture a frame
vec_in  in  FEATURE_BITWIDTH*FLATTENED_SIZE  flattened vector, element e at bits [e*FEATURE_BITWIDTH +: FEATURE_BITWIDTH]
beat_valid  out  1  beat_data valid
beat_ready  in  1  FC stage accepts beat
beat_data  out  FEATURE_BITWIDTH*LANES  lane L = element beat_idx*LANES+L, lane 0 at LSBs
beat_idx  out  IDX_W  index of current beat, 0..NUM_BEATS-1
beat_last  out  1  high with the final beat of a frame
frame_done  out  1  one-cycle pulse after the final beat is accepted
busy  out  1  frame held or streaming
frame_count  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- FSM states: IDLE, STREAM.
- Reset values (rst_n low, or soft_rst high at an edge): state IDLE, vec_ready 1, beat_valid 0, beat_idx 0, beat_last 0, frame_done 0, busy 0, frame_count 0. Buffer contents are don't-care.
- IDLE:
  - vec_ready = 1.
  - On vec_valid & vec_ready: capture vec_in into the buffer, beat_idx <= 0, go to STREAM.
  - beat_valid rises the cycle after the capture (latency 1).
- STREAM:
  - vec_ready = 0. vec_valid is ignored and the upstream producer must hold.
  - beat_valid = 1, busy = 1.
  - On beat_valid & beat_ready: beat_idx increments.
  - Without a handshake, beat_data, beat_idx and beat_last hold stable.
- beat_last = beat_valid & (beat_idx == NUM_BEATS-1).
- Handshake on the last beat:
  - Next cycle: frame_done = 1 for exactly one cycle, frame_count += 1, state IDLE, vec_ready = 1, beat_valid = 0.
  - Frame period with beat_ready tied high: NUM_BEATS+1 cycles (37).
- beat_data:
  - Combinational slice of the registered buffer, selected by beat_idx.
  - Forced to all zeros when beat_valid = 0.
  - Lanes whose element index is >= FLATTENED_SIZE (partial last beat) read zero.
- Reset mid-frame (async or soft): the frame is aborted. No frame_done, no frame_count increment, beat_valid drops immediately (async) or next cycle (soft).
- soft_rst has priority over any handshake in the same cycle.
- vec_valid and soft_rst high together: no capture.
- No combinational path from beat_ready to vec_ready.

Decomposition:
- Shared package (mnist_pkg): FEATURE_BITWIDTH, FLATTENED_SIZE, FC_LANES constants, and a clog2 function.
- One sub-module, flat_beat_select: purely combinational LANES-wide slicer. Inputs are buffer and beat_idx; output is the lane data with zero-padding beyond FLATTENED_SIZE.
- The FSM, counters and buffer stay in the top module.

Test Plan:
1. Element e = e[7:0], beat_ready = 1.
   - Capture at cycle 0 -> beat_valid cycles 1..36.
   - Beat 0 lanes = 0x00..0x07; beat 35 lanes = 0x18..0x1F with beat_last = 1.
   - frame_done pulse at cycle 37; frame_count = 1.
2. Back-pressure: beat_ready low on odd cycles.
   - beat_data and beat_idx are stable during stalls.
   - All 36 beats are seen exactly once, in order; frame_done follows the 36th accept.
3. vec_valid held high with a new vector during STREAM.
   - vec_ready stays 0 and there is no capture.
   - The second frame is captured in the first IDLE cycle after frame_done; its beat 0 reflects the new vector.
4. soft_rst at beat_idx = 10.
   - Next cycle: beat_valid = 0, vec_ready = 1, beat_idx = 0.
   - No frame_done; frame_count unchanged.
5. rst_n pulsed low asynchronously mid-beat.
   - Outputs go to reset values without waiting for a clock edge; frame_count = 0.
6. Override FLATTENED_SIZE = 20, LANES = 8.
   - 3 beats are produced.
   - Beat 2 lanes 0..3 = elements 16..19, lanes 4..7 = 0, with beat_last = 1.
